// File: rtl/sevseg_pkg.sv
// Shared constants for the seven-segment bus monitor: segment codes, digit
// select codes, error encodings and the frame FSM state type.
package sevseg_pkg;

  // Segment patterns on bits [6:0] (g..a); decimal point excluded.
  localparam logic [6:0] SEG_0 = 7'b0111111;
  localparam logic [6:0] SEG_1 = 7'b0000110;
  localparam logic [6:0] SEG_2 = 7'b1011011;
  localparam logic [6:0] SEG_3 = 7'b1001111;
  localparam logic [6:0] SEG_4 = 7'b1100110;
  localparam logic [6:0] SEG_5 = 7'b1101101;
  localparam logic [6:0] SEG_6 = 7'b1111101;
  localparam logic [6:0] SEG_7 = 7'b0000111;

  localparam logic [4:0] SEL_BLANK = 5'b00000;
  localparam logic [4:0] SEL_POS0  = 5'b01000;
  localparam logic [4:0] SEL_POS1  = 5'b00100;
  localparam logic [4:0] SEL_POS2  = 5'b00010;
  localparam logic [4:0] SEL_POS3  = 5'b00001;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_PATTERN = 2'b01;
  localparam logic [1:0] ERR_ORDER   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    EXP1 = 2'd1,
    EXP2 = 2'd2,
    EXP3 = 2'd3
  } state_e;

  typedef struct packed {
    logic       bad;
    logic [1:0] pos;
  } sel_info_t;

  function automatic sel_info_t decode_sel(input logic [4:0] sel);
    sel_info_t r;
    r.bad = 1'b0;
    r.pos = 2'd0;
    case (sel)
      SEL_POS0: r.pos = 2'd0;
      SEL_POS1: r.pos = 2'd1;
      SEL_POS2: r.pos = 2'd2;
      SEL_POS3: r.pos = 2'd3;
      default:  r.bad = 1'b1;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] exp_pos(input state_e s);
    logic [1:0] p;
    case (s)
      EXP1:    p = 2'd1;
      EXP2:    p = 2'd2;
      EXP3:    p = 2'd3;
      default: p = 2'd0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/sevseg_decode.sv
// Combinational seven-segment to 3-bit value decoder; anything outside the
// eight legal digit patterns (including 8 and 9) is flagged bad.
module sevseg_decode
  import sevseg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [2:0] value,
  output logic       bad
);

  always_comb begin
    value = 3'd0;
    bad   = 1'b0;
    case (pattern)
      SEG_0:   value = 3'd0;
      SEG_1:   value = 3'd1;
      SEG_2:   value = 3'd2;
      SEG_3:   value = 3'd3;
      SEG_4:   value = 3'd4;
      SEG_5:   value = 3'd5;
      SEG_6:   value = 3'd6;
      SEG_7:   value = 3'd7;
      default: bad   = 1'b1;
    endcase
  end

endmodule

// File: rtl/sevseg_scan_capture.sv
// Seven-segment scan bus monitor: filters dwells, decodes digits, reassembles frames.
// Build option SEVSEG_RX_TIMEOUT_EN adds an inter-digit timeout (err_code 11).
module sevseg_scan_capture
  import sevseg_pkg::*;
#(
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 8192
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  set_Data,
  input  logic [4:0]  see_sel,
  output logic [11:0] word,
  output logic        word_valid,
  output logic        frame_err,
  output logic [1:0]  err_code
);

  localparam logic [7:0] SETTLE_C = 8'(SETTLE);

  logic [6:0]       seg_q, seg_d;
  logic [4:0]       sel_q, sel_d;
  logic [7:0]       stab_cnt_q, stab_cnt_d;
  logic             pair_same;
  logic             accept;

  state_e           state_q, state_d;
  logic [3:0][2:0]  field_q, field_d;
  logic [11:0]      word_q, word_d;
  logic             word_valid_q, word_valid_d;
  logic             frame_err_q, frame_err_d;
  logic [1:0]       err_code_q, err_code_d;

  logic [2:0]       dec_value;
  logic             dec_bad;
  sel_info_t        sinfo;

  // The decimal point carries no information for the monitor.
  logic unused_dp;
  assign unused_dp = set_Data[7];

  sevseg_decode u_decode (
    .pattern (set_Data[6:0]),
    .value   (dec_value),
    .bad     (dec_bad)
  );

  // Acceptance fires only on the edge the count first reaches SETTLE.
  always_comb begin
    seg_d     = set_Data[6:0];
    sel_d     = see_sel;
    pair_same = (seg_d == seg_q) && (sel_d == sel_q);
    if (!pair_same) begin
      stab_cnt_d = 8'd1;
    end else if (stab_cnt_q == SETTLE_C) begin
      stab_cnt_d = stab_cnt_q;
    end else begin
      stab_cnt_d = stab_cnt_q + 8'd1;
    end
    accept = (stab_cnt_d == SETTLE_C) &&
             (!pair_same || (stab_cnt_q != SETTLE_C)) &&
             (see_sel != SEL_BLANK);
  end

`ifdef SEVSEG_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          tmo_hit;

  always_comb begin
    tmo_cnt_d = '0;
    tmo_hit   = 1'b0;
    if (!accept && (state_q != SYNC)) begin
      tmo_cnt_d = tmo_cnt_q + TW'(1);
      if (tmo_cnt_d == TW'(TIMEOUT)) begin
        tmo_hit   = 1'b1;
        tmo_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`endif

  always_comb begin
    state_d      = state_q;
    field_d      = field_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    err_code_d   = ERR_NONE;
    sinfo        = decode_sel(see_sel);

    if (accept) begin
      if (!sinfo.bad && (sinfo.pos == 2'd0)) begin
        // Position 0 always restarts a frame; interrupting one is an order fault.
        if (dec_bad) begin
          frame_err_d = 1'b1;
          err_code_d  = ERR_PATTERN;
          state_d     = SYNC;
        end else begin
          field_d[0] = dec_value;
          state_d    = EXP1;
          if (state_q != SYNC) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_ORDER;
          end
        end
      end else if (state_q != SYNC) begin
        if (sinfo.bad || (sinfo.pos != exp_pos(state_q))) begin
          frame_err_d = 1'b1;
          err_code_d  = ERR_ORDER;
          state_d     = SYNC;
        end else if (dec_bad) begin
          frame_err_d = 1'b1;
          err_code_d  = ERR_PATTERN;
          state_d     = SYNC;
        end else begin
          field_d[sinfo.pos] = dec_value;
          case (state_q)
            EXP1: state_d = EXP2;
            EXP2: state_d = EXP3;
            EXP3: begin
              word_d       = {dec_value, field_q[2], field_q[1], field_q[0]};
              word_valid_d = 1'b1;
              state_d      = SYNC;
            end
            default: state_d = SYNC;
          endcase
        end
      end
    end
`ifdef SEVSEG_RX_TIMEOUT_EN
    else if (tmo_hit) begin
      frame_err_d = 1'b1;
      err_code_d  = ERR_TIMEOUT;
      state_d     = SYNC;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q        <= '0;
      sel_q        <= '0;
      stab_cnt_q   <= '0;
      state_q      <= SYNC;
      field_q      <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      err_code_q   <= ERR_NONE;
    end else begin
      seg_q        <= seg_d;
      sel_q        <= sel_d;
      stab_cnt_q   <= stab_cnt_d;
      state_q      <= state_d;
      field_q      <= field_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      frame_err_q  <= frame_err_d;
      err_code_q   <= err_code_d;
    end
  end

  assign word       = word_q;
  assign word_valid = word_valid_q;
  assign frame_err  = frame_err_q;
  assign err_code   = err_code_q;

endmodule
